// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle logic/add/sub/pass ops and an iterative shift-add MUL,
// with valid/ready handshakes on both sides and an NZCV register updated at output transfer.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       flags
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       pflags_q, pflags_d;
  logic             setf_q, setf_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             is_mul, accept;
  logic [WIDTH-1:0] alu_res, acc_nxt;
  logic [WIDTH:0]   alu_sum;
  logic             alu_c, alu_v;

  assign is_mul = (alucontrol[3:0] == 4'b0011);
  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_sum = '0;
    case (alucontrol[3:0])
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0010: begin
        alu_sum = {1'b0, a} + {1'b0, b};
        alu_res = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = a - b;
        alu_c   = (a >= b);
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: alu_res = b;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      flags_q  <= '0;
      pflags_q <= '0;
      setf_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      pflags_q <= pflags_d;
      setf_q   <= setf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (in_valid) state_d = is_mul ? StMul : StDone;
      StMul:  if (cnt_q == CntLast) state_d = StDone;
      StDone: begin
        if (out_ready) begin
          if (in_valid) state_d = is_mul ? StMul : StDone;
          else          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    pflags_d = pflags_q;
    setf_d   = setf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_nxt  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Flags commit from the op leaving the stage, before any newly accepted op overwrites it.
    if (state_q == StDone && out_ready && setf_q) flags_d = pflags_q;

    if (state_q == StMul) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CntLast) begin
        result_d = acc_nxt;
        pflags_d = {acc_nxt[WIDTH-1], acc_nxt == '0, 2'b00};
        cnt_d    = '0;
      end
    end

    if (accept) begin
      setf_d = alucontrol[4];
      if (is_mul) begin
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        result_d = alu_res;
        pflags_d = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
      end
    end
  end

  always_comb begin
    in_ready  = !reset && ((state_q == StIdle) || (state_q == StDone && out_ready));
    out_valid = (state_q == StDone);
    result    = result_q;
    zero      = (result_q == '0);
    flags     = flags_q;
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_exec_stage;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   alucontrol;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic [3:0]   flags;

  int n_checks = 0;
  int n_err    = 0;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alucontrol(alucontrol),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: result and NZCV straight from the arithmetic definitions.
  function automatic logic [W+3:0] ref_op(input logic [3:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0]     r;
    logic             c, v;
    logic [2*W-1:0]   p;
    logic signed [W:0] ss;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin
        r  = x + y;
        c  = ({1'b0, x} + {1'b0, y}) > {1'b0, {W{1'b1}}};
        ss = $signed({x[W-1], x}) + $signed({y[W-1], y});
        v  = (ss > $signed({2'b00, {(W-1){1'b1}}})) || (ss < -$signed({2'b01, {(W-1){1'b0}}}));
      end
      4'd6: begin
        r  = x - y;
        c  = (x >= y);
        ss = $signed({x[W-1], x}) - $signed({y[W-1], y});
        v  = (ss > $signed({2'b00, {(W-1){1'b1}}})) || (ss < -$signed({2'b01, {(W-1){1'b0}}}));
      end
      4'd7: r = y;
      4'd3: begin p = x * y; r = p[W-1:0]; end
      default: r = '0;
    endcase
    return {r[W-1], r == '0, c, v, r};
  endfunction

  // Transaction-level model: busy countdown for MUL, one held result, architectural flags.
  int           m_busy;
  bit           m_have;
  logic [W-1:0] m_res, m_mres;
  logic [3:0]   m_pf, m_mpf, m_flags;
  bit           m_setf, m_msetf;

  always @(negedge clk) begin
    logic [W+3:0] rr;
    bit exp_ir;
    if (reset) begin
      m_busy = 0; m_have = 0; m_res = '0; m_flags = '0; m_setf = 0;
      chk("rst_in_ready", {63'd0, in_ready}, 0);
      chk("rst_out_valid", {63'd0, out_valid}, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {60'd0, flags}, 0);
    end else begin
      exp_ir = (m_busy == 0) && (!m_have || out_ready);
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_have});
      if (m_have) begin
        chk("result", result, m_res);
        chk("zero", {63'd0, zero}, {63'd0, m_res == '0});
      end
      chk("flags", {60'd0, flags}, {60'd0, m_flags});
      if (m_have && out_ready) begin
        if (m_setf) m_flags = m_pf;
        m_have = 0;
      end
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_have = 1; m_res = m_mres; m_pf = m_mpf; m_setf = m_msetf;
        end
      end
      if (in_valid && exp_ir) begin
        rr = ref_op(alucontrol[3:0], a, b);
        if (alucontrol[3:0] == 4'd3) begin
          m_busy = W; m_mres = rr[W-1:0]; m_mpf = {rr[W+3:W+2], 2'b00}; m_msetf = alucontrol[4];
        end else begin
          m_have = 1; m_res = rr[W-1:0]; m_pf = rr[W+3:W]; m_setf = alucontrol[4];
        end
      end
    end
  end

  task automatic send(input logic [4:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    bit got;
    in_valid = 1; alucontrol = c; a = x; b = y;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL send_timeout: got no in_ready expected acceptance");
    end
    in_valid = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; alucontrol = 5'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; in_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      4: return W'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [8];
    logic [W-1:0] orv [5];
    int late;
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd4, 4'd15};
    reset = 1; in_valid = 0; out_ready = 0; alucontrol = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // ADD without flags, result held while out_ready low
    send(5'b00010, 5, 7);
    @(negedge clk);
    chk("t1_valid", {63'd0, out_valid}, 1);
    chk("t1_result", result, 12);
    chk("t1_zero", {63'd0, zero}, 0);
    chk("t1_flags", {60'd0, flags}, 0);
    @(posedge clk); #1 out_ready = 1;

    send(5'b10110, 3, 3);
    @(negedge clk);
    chk("t2_result", result, 0);
    chk("t2_zero", {63'd0, zero}, 1);
    @(negedge clk);
    chk("t2_flags", {60'd0, flags}, 4'b0110);

    send(5'b10010, 64'h7FFF_FFFF_FFFF_FFFF, 1);
    @(negedge clk);
    chk("t3_result", result, 64'h8000_0000_0000_0000);
    @(negedge clk);
    chk("t3_flags", {60'd0, flags}, 4'b1001);
    send(5'b00000, 64'hF0, 64'h3C);
    @(negedge clk);
    chk("t3_and", result, 64'h30);
    @(negedge clk);
    chk("t3_flags_hold", {60'd0, flags}, 4'b1001);

    @(posedge clk); #1 out_ready = 0;
    send(5'b00011, 6, 7);
    late = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (in_ready || out_valid) late++;
    end
    chk("t4_busy_cycles", late, 0);
    @(negedge clk);
    chk("t4_valid", {63'd0, out_valid}, 1);
    chk("t4_result", result, 42);
    @(posedge clk); #1;
    in_valid = 1; alucontrol = 5'b00001; a = 1; b = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_result", result, 42);
      chk("t4_hold_ready", {63'd0, in_ready}, 0);
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;

    // back-to-back ORR
    for (int k = 0; k < 5; k++) begin
      orv[k] = W'(k + 1) | (W'(k + 1) << 8);
      in_valid = 1; alucontrol = 5'b00001; a = W'(k + 1); b = W'(k + 1) << 8;
      @(negedge clk);
      chk("t5_ready", {63'd0, in_ready}, 1);
      if (k > 0) chk("t5_result", result, orv[k-1]);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("t5_last", result, orv[4]);
    send(5'b10010, 64'h7FFF_FFFF_FFFF_FFFF, 1);
    @(negedge clk); @(negedge clk);
    chk("t6_pre_flags", {60'd0, flags}, 4'b1001);

    // reset during MUL
    send(5'b10011, 64'h1234, 64'h5678);
    repeat (19) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("t6_valid", {63'd0, out_valid}, 0);
    chk("t6_result", result, 0);
    chk("t6_flags", {60'd0, flags}, 0);
    @(posedge clk); #1 reset = 0;
    late = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge clk);
      if (out_valid) late++;
    end
    chk("t6_no_late", late, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      out_ready  = ($urandom_range(0, 3) != 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      alucontrol = {1'($urandom), ($urandom_range(0, 9) == 0) ? 4'd3 : ops[$urandom_range(0, 7)]};
      if (alucontrol[3:0] == 4'd3 && $urandom_range(0, 2) != 0) alucontrol[3:0] = 4'd2;
      a = rnd_opnd();
      b = rnd_opnd();
      if (i == 1500) reset = 1;
      if (i == 1502) reset = 0;
    end
    in_valid = 0; out_ready = 1;
    repeat (W + 5) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
